// File: rtl/micro_seq_pkg.sv
// rtl/micro_seq_pkg.sv - shared op encodings, FSM states and defaults for the micro sequencer
package micro_seq_pkg;

    localparam int DEFAULT_ADDR_WIDTH = 11;

    typedef enum logic [2:0] {
        OP_NEXT     = 3'b000,
        OP_JUMP     = 3'b001,
        OP_BRANCH   = 3'b010,
        OP_CALL     = 3'b011,
        OP_RET      = 3'b100,
        OP_HOLD     = 3'b101,
        OP_DISPATCH = 3'b110,
        OP_ILLEGAL  = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_ERROR = 2'd2
    } state_e;

endpackage

// File: rtl/micro_return_stack.sv
// rtl/micro_return_stack.sv - LIFO of micro return addresses; only the occupancy pointer is reset
module micro_return_stack #(
    parameter int ADDR_WIDTH  = 11,
    parameter int STACK_DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           i_push,
    input  logic                           i_pop,
    input  logic [ADDR_WIDTH-1:0]          i_data,
    output logic [ADDR_WIDTH-1:0]          o_top,
    output logic [$clog2(STACK_DEPTH):0]   o_depth,
    output logic                           o_full,
    output logic                           o_empty
);

    localparam int PW = $clog2(STACK_DEPTH);
    localparam int DW = PW + 1;

    logic [ADDR_WIDTH-1:0] r_mem [STACK_DEPTH];
    logic [DW-1:0]         r_depth;
    logic [PW-1:0]         w_wr_idx;
    logic [PW-1:0]         w_rd_idx;
    logic                  w_do_push;
    logic                  w_do_pop;

    assign o_full    = (r_depth == DW'(STACK_DEPTH));
    assign o_empty   = (r_depth == '0);
    assign w_wr_idx  = r_depth[PW-1:0];
    assign w_rd_idx  = PW'(r_depth - DW'(1));
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty && !i_push;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_depth <= '0;
        end else if (w_do_push) begin
            r_depth <= r_depth + DW'(1);
        end else if (w_do_pop) begin
            r_depth <= r_depth - DW'(1);
        end
    end

    // Entry contents are don't-care after reset, so the array carries no reset.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[w_wr_idx] <= i_data;
        end
    end

    assign o_top   = r_mem[w_rd_idx];
    assign o_depth = r_depth;

endmodule

// File: rtl/micro_addr_sequencer.sv
// rtl/micro_addr_sequencer.sv - micro-PC, next-address selection and sequencing FSM
module micro_addr_sequencer
    import micro_seq_pkg::*;
#(
    parameter int          ADDR_WIDTH   = DEFAULT_ADDR_WIDTH,
    parameter int          STACK_DEPTH  = 4,
    parameter int unsigned RESET_VECTOR = 0
) (
    input  logic                          MAS_CLOCK_50,
    input  logic                          MAS_RESET_InHigh,
    input  logic                          MAS_Ack_IN,
    input  logic                          MAS_Stall_IN,
    input  logic [2:0]                    MAS_Op_IN,
    input  logic                          MAS_Cond_IN,
    input  logic [ADDR_WIDTH-1:0]         MAS_Target_IN,
    input  logic [ADDR_WIDTH-1:0]         MAS_Dispatch_IN,
    output logic [ADDR_WIDTH-1:0]         MAS_Address_OUT,
    output logic                          MAS_Req_OUT,
    output logic [$clog2(STACK_DEPTH):0]  MAS_Depth_OUT,
    output logic                          MAS_Error_OUT
);

    state_e                r_state;
    state_e                w_state_next;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH-1:0] w_addr_next;
    logic [ADDR_WIDTH-1:0] w_addr_inc;
    logic [ADDR_WIDTH-1:0] w_stack_top;
    logic                  w_step;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_fault;
    logic                  w_full;
    logic                  w_empty;
    op_e                   w_op;

    assign w_op       = op_e'(MAS_Op_IN);
    assign w_step     = (r_state == ST_RUN) && MAS_Ack_IN && !MAS_Stall_IN;
    assign w_addr_inc = r_addr + ADDR_WIDTH'(1);

    always_comb begin
        w_state_next = r_state;
        w_addr_next  = r_addr;
        w_push       = 1'b0;
        w_pop        = 1'b0;
        w_fault      = 1'b0;
        case (r_state)
            ST_BOOT: w_state_next = ST_RUN;
            ST_RUN: begin
                if (w_step) begin
                    case (w_op)
                        OP_NEXT:     w_addr_next = w_addr_inc;
                        OP_JUMP:     w_addr_next = MAS_Target_IN;
                        OP_BRANCH:   w_addr_next = MAS_Cond_IN ? MAS_Target_IN : w_addr_inc;
                        OP_CALL: begin
                            if (w_full) begin
                                w_fault = 1'b1;
                            end else begin
                                w_push      = 1'b1;
                                w_addr_next = MAS_Target_IN;
                            end
                        end
                        OP_RET: begin
                            if (w_empty) begin
                                w_fault = 1'b1;
                            end else begin
                                w_pop       = 1'b1;
                                w_addr_next = w_stack_top;
                            end
                        end
                        OP_HOLD:     w_addr_next = r_addr;
                        OP_DISPATCH: w_addr_next = MAS_Dispatch_IN;
                        default:     w_fault = 1'b1;
                    endcase
                end
                if (w_fault) begin
                    w_state_next = ST_ERROR;
                end
            end
            default: w_state_next = ST_ERROR;
        endcase
    end

    always_ff @(posedge MAS_CLOCK_50) begin
        if (MAS_RESET_InHigh) begin
            r_state <= ST_BOOT;
            r_addr  <= ADDR_WIDTH'(RESET_VECTOR);
        end else begin
            r_state <= w_state_next;
            r_addr  <= w_addr_next;
        end
    end

    // Return address is the wrapped increment, so a CALL at the top of the store returns to 0.
    micro_return_stack #(
        .ADDR_WIDTH  (ADDR_WIDTH),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk     (MAS_CLOCK_50),
        .rst     (MAS_RESET_InHigh),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (w_addr_inc),
        .o_top   (w_stack_top),
        .o_depth (MAS_Depth_OUT),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign MAS_Address_OUT = r_addr;
    assign MAS_Req_OUT     = (r_state == ST_RUN);
    assign MAS_Error_OUT   = (r_state == ST_ERROR);

endmodule
